// File: rtl/ibex_ex_issue_ctrl_if.sv
// Signal bundle between the ID-side issue controller and its neighbours
// (ID stage, execution block, writeback). clk/reset stay as plain ports.
interface ibex_ex_issue_ctrl_if;
    logic        instr_valid_i;
    logic        instr_mult_i;
    logic        instr_div_i;
    logic        flush_i;
    logic        wb_ready_i;
    logic        ex_valid_i;
    logic        imd_val_we_i;
    logic [33:0] imd_val_d_i;

    logic [33:0] imd_val_q_o;
    logic        mult_en_o;
    logic        div_en_o;
    logic        mult_sel_o;
    logic        div_sel_o;
    logic        alu_instr_first_cycle_o;
    logic        multdiv_ready_id_o;
    logic        instr_done_o;
    logic        id_stall_o;
    logic [31:0] perf_ex_stall_cnt_o;

    // Surrounding pipeline side: presents instructions and EX results.
    modport master (
        output instr_valid_i, instr_mult_i, instr_div_i, flush_i,
               wb_ready_i, ex_valid_i, imd_val_we_i, imd_val_d_i,
        input  imd_val_q_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
               alu_instr_first_cycle_o, multdiv_ready_id_o, instr_done_o,
               id_stall_o, perf_ex_stall_cnt_o
    );

    // Issue controller side.
    modport slave (
        input  instr_valid_i, instr_mult_i, instr_div_i, flush_i,
               wb_ready_i, ex_valid_i, imd_val_we_i, imd_val_d_i,
        output imd_val_q_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
               alu_instr_first_cycle_o, multdiv_ready_id_o, instr_done_o,
               id_stall_o, perf_ex_stall_cnt_o
    );
endinterface

// File: rtl/ibex_ex_issue_ctrl.sv
// ID-side issue controller for the execution block: sequences multi-cycle ops,
// owns the 34-bit intermediate register. Optional stall counter: IBEX_EX_ISSUE_PERF_EN.
module ibex_ex_issue_ctrl #(
    parameter bit RV32M = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_ex_issue_ctrl_if.slave  ex_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } state_e;

    state_e      state_reg;
    state_e      state_next;
    logic [33:0] imd_val_reg;

    logic fire;
    logic done;
    logic is_mult;
    logic is_div;
    logic mult_sel;
    logic div_sel;
    logic first_cycle;
    logic id_stall;
    logic multdiv_ready;

    // Without the M extension, mult/div decode bits are ignored entirely so the
    // instruction flows through as a plain ALU op.
    generate
        if (RV32M) begin : g_multdiv
            assign is_mult = ex_bus.instr_mult_i;
            assign is_div  = ex_bus.instr_div_i;
        end else begin : g_no_multdiv
            assign is_mult = 1'b0;
            assign is_div  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        fire          = 1'b0;
        done          = 1'b0;
        mult_sel      = 1'b0;
        div_sel       = 1'b0;
        first_cycle   = 1'b0;
        id_stall      = 1'b0;
        multdiv_ready = 1'b0;
        state_next    = state_reg;

        // KILL masks the held instruction for one cycle so the multdiv FSM
        // sees its enables drop and returns to idle before re-issue.
        fire          = ex_bus.instr_valid_i & ~ex_bus.flush_i & (state_reg != KILL);
        done          = fire & ex_bus.ex_valid_i & ex_bus.wb_ready_i;
        mult_sel      = fire & is_mult;
        div_sel       = fire & is_div;
        first_cycle   = fire & (state_reg == IDLE);
        id_stall      = ex_bus.instr_valid_i & ~done;
        multdiv_ready = ex_bus.wb_ready_i & ~ex_bus.flush_i;

        unique case (state_reg)
            IDLE: begin
                if (ex_bus.flush_i) begin
                    state_next = KILL;
                end else if (fire && !done) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end else if (ex_bus.flush_i) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ex_bus.instr_done_o            = done;
    assign ex_bus.id_stall_o              = id_stall;
    assign ex_bus.mult_sel_o              = mult_sel;
    assign ex_bus.div_sel_o               = div_sel;
    assign ex_bus.mult_en_o               = mult_sel;
    assign ex_bus.div_en_o                = div_sel;
    assign ex_bus.alu_instr_first_cycle_o = first_cycle;
    assign ex_bus.multdiv_ready_id_o      = multdiv_ready;

    // ------------------------------------------------------------------
    // Intermediate value register: survives flush and retire on purpose,
    // EX overwrites it before any instruction reads it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imd_val_reg <= 34'd0;
        end else if (ex_bus.imd_val_we_i && fire) begin
            imd_val_reg <= ex_bus.imd_val_d_i;
        end
    end

    assign ex_bus.imd_val_q_o = imd_val_reg;

    // ------------------------------------------------------------------
    // EX stall cycle counter (saturating)
    // ------------------------------------------------------------------
`ifdef IBEX_EX_ISSUE_PERF_EN
    logic [31:0] perf_cnt_reg;
    logic        perf_inc;

    assign perf_inc = ex_bus.instr_valid_i & ~done & ~ex_bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_reg <= 32'd0;
        end else if (perf_inc && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end

    assign ex_bus.perf_ex_stall_cnt_o = perf_cnt_reg;
`else
    assign ex_bus.perf_ex_stall_cnt_o = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    a_kill_one_cycle : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_reg == KILL) |=> (state_reg == IDLE)
    );

    a_no_done_in_kill : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_reg == KILL) |-> !done
    );

    a_state_legal : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        state_reg inside {IDLE, BUSY, KILL}
    );

endmodule

// File: doc/ibex_ex_issue_ctrl.md
# ibex_ex_issue_ctrl

ID-side issue controller for the execution block: drives the ALU/multdiv enable and select inputs, owns the 34-bit intermediate value register, and accepts results from EX. It sits between the ID stage and the execution block. It sequences multi-cycle ALU and MUL/DIV instructions, grants `multdiv_ready_id` when writeback can accept, and stalls ID until EX reports valid.

## Interface
Parameters:
- `RV32M`, 1, multdiv present; when 0, `mult_*`/`div_*` outputs tied 0 and `instr_mult_i`/`instr_div_i` ignored (instruction treated as ALU op)

Ports:
- `clk_i` in 1: clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `instr_valid_i` in 1: ID presents an instruction to EX (held until `instr_done_o`)
- `instr_mult_i` in 1: instruction is MUL*
- `instr_div_i` in 1: instruction is DIV*/REM*
- `flush_i` in 1: kill in-flight instruction
- `wb_ready_i` in 1: writeback can accept a result this cycle
- `ex_valid_i` in 1: EX has valid output
- `imd_val_we_i` in 1: EX write enable for intermediate register
- `imd_val_d_i` in 34: intermediate value from EX
- `imd_val_q_o` out 34: intermediate register contents
- `mult_en_o`, `div_en_o` out 1: dynamic enables (FSM control)
- `mult_sel_o`, `div_sel_o` out 1: static selects (data muxes)
- `alu_instr_first_cycle_o` out 1: first cycle of current instruction
- `multdiv_ready_id_o` out 1: ID ready to take multdiv result
- `instr_done_o` out 1: instruction retires from EX this cycle
- `id_stall_o` out 1: ID must hold its instruction
- `perf_ex_stall_cnt_o` out 32: EX stall cycle count

## Operation
- States: IDLE (next valid cycle is a first cycle), BUSY (mid-instruction), KILL (one-cycle post-flush quiesce).
- `fire = instr_valid_i & ~flush_i & state!=KILL`.
- `done = fire & ex_valid_i & wb_ready_i`. `instr_done_o = done`.
- `id_stall_o = instr_valid_i & ~done`.
- `mult_sel_o = fire & instr_mult_i`. `div_sel_o = fire & instr_div_i`.
- `mult_en_o = mult_sel_o`. `div_en_o = div_sel_o`.
- `alu_instr_first_cycle_o = fire & state==IDLE`.
- `multdiv_ready_id_o = wb_ready_i & ~flush_i`.
- Transitions:
  - IDLE: `done` stays in IDLE. `fire & ~done` goes to BUSY. `flush_i` goes to KILL.
  - BUSY: `done` goes to IDLE. `flush_i` goes to KILL. Otherwise stays in BUSY.
  - KILL: always goes to IDLE. All enables/selects/first_cycle are 0 in KILL, so the multdiv FSM returns to idle.
- Intermediate register: loads `imd_val_d_i` when `imd_val_we_i & fire`. It holds otherwise and is not cleared by flush or done.
- Simultaneous `flush_i` and `ex_valid_i`: flush wins, no `instr_done_o`, next state KILL.
- `ex_valid_i` while `wb_ready_i`=0: no retire, state unchanged, enables stay high, EX holds its result.

## Timing
- All control outputs are combinational from inputs and state; state and registers update on the rising edge of `clk_i`.
- Single-cycle ALU op: retires in the issue cycle, `alu_instr_first_cycle_o`=1 in that cycle.
- A back-to-back next instruction sees `alu_instr_first_cycle_o`=1 in the following cycle.
- Multi-cycle op of N EX cycles: first_cycle=1 only in cycle 1; `instr_done_o` in cycle N (if `wb_ready_i`).
- Imd write in cycle k is visible on `imd_val_q_o` in cycle k+1.
- Reset (asynchronous, any time including mid-operation): state is IDLE, `imd_val_q_o`=0, counter=0. With `instr_valid_i`=0, every other output is 0 except `multdiv_ready_id_o`, which follows `wb_ready_i`.

## Configuration
- `IBEX_EX_ISSUE_PERF_EN` defined: `perf_ex_stall_cnt_o` increments each cycle `instr_valid_i & ~done & ~flush_i`, saturates at 0xFFFF_FFFF, and is reset to 0.
- Not defined: the port exists and is tied to 0, with no counter flops.

## Test plan
- ADD with `ex_valid_i`=1, `wb_ready_i`=1 in cycle 0 -> `alu_instr_first_cycle_o`=1, `instr_done_o`=1 in cycle 0, state IDLE, `id_stall_o`=0.
- DIV, `ex_valid_i` asserted in cycle 36 -> `div_en_o`/`div_sel_o`=1 in cycles 0–36, first_cycle only in cycle 0, `instr_done_o` in cycle 36. With PERF_EN, counter reads 36.
- MUL with `imd_val_we_i`=1, `imd_val_d_i`=34'h2_DEAD_BEEF in cycle 1 -> `imd_val_q_o`=34'h2_DEAD_BEEF in cycle 2. Value is held after done.
- MUL: `ex_valid_i`=1 in cycle 3, `wb_ready_i`=0 in cycles 3–5 -> `multdiv_ready_id_o`=0 and no done in cycles 3–5. In cycle 6 (`wb_ready_i`=1): `instr_done_o`=1.
- DIV in BUSY, `flush_i`=1 together with `ex_valid_i`=1 -> no `instr_done_o`. Next cycle is KILL with `div_en_o`=0 even though `instr_valid_i`=1. The cycle after, the instruction shows first_cycle=1.
- `rst_ni` pulsed low mid-MUL (async, between edges) -> `imd_val_q_o`=0 and state IDLE immediately. After release, the next valid shows first_cycle=1.
